// File: rtl/multi_cycle_addsub_if.sv
// Operand/result bundle for the multi-cycle chunked adder/subtractor.
// The master drives the request; the slave (the datapath) returns status and result.
interface multi_cycle_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, co, ov
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, co, ov
    );
endinterface

// File: rtl/multi_cycle_addsub.sv
// Adder/subtractor that ripples CHUNK bits per clock, LSB chunk first, over WIDTH/CHUNK cycles.
// Subtraction is a + ~b + 1, so co means "no borrow" in that mode.
module multi_cycle_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst,
    multi_cycle_addsub_if.slave bus
);
    localparam int unsigned NSTEP = WIDTH / CHUNK;
    localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             co_q;
    logic             ov_q;

    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] sum;
    logic [CHUNK:0]   carry;
    logic [WIDTH-1:0] s_next;
    logic             last;

    // One chunk of full-add cells on the slice selected by the step counter.
    always_comb begin
        x        = CHUNK'(a_q >> (cnt_q * CHUNK));
        y        = CHUNK'(b_q >> (cnt_q * CHUNK));
        sum      = '0;
        carry    = '0;
        carry[0] = c_q;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]     = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
        end
        s_next = s_q;
        for (int unsigned k = 0; k < NSTEP; k++) begin
            if (cnt_q == CW'(k)) begin
                s_next[k*CHUNK +: CHUNK] = sum;
            end
        end
        last = (cnt_q == CW'(NSTEP - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            case (state_q)
                // DONE accepts a new request exactly like IDLE for back-to-back throughput.
                StIdle, StDone: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {WIDTH{bus.sub}};
                        c_q     <= bus.sub;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    s_q   <= s_next;
                    c_q   <= carry[CHUNK];
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        co_q    <= carry[CHUNK];
                        ov_q    <= carry[CHUNK] ^ carry[CHUNK-1];
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ov   = ov_q;
endmodule

// File: tb/tb_multi_cycle_addsub.sv
// Scoreboard bench for multi_cycle_addsub: expected results are queued at start and popped on done.
module tb_multi_cycle_addsub;
    localparam int W     = 16;
    localparam int C     = 4;
    localparam int NSTEP = W / C;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_cycle_addsub_if #(.WIDTH(W)) bus ();

    multi_cycle_addsub #(
        .WIDTH(W),
        .CHUNK(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] full;
        res_t       r;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            r.co = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            r.co = full[W];
        end
        r.s = full[W-1:0];
        if (sub) r.ov = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
        else     r.ov = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if ({bus.s, bus.co, bus.ov} !== '0) begin
            bad++; $display("FAIL reset_out: got s=%h co=%b ov=%b want all 0", bus.s, bus.co, bus.ov);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic         vs [8];
        res_t         e;
        int           n;
        int           busy_n;
        bit           seen;
        va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 1'b0;
        va[1] = 16'h7FFF; vb[1] = 16'h0001; vs[1] = 1'b0;
        va[2] = 16'h0005; vb[2] = 16'h0007; vs[2] = 1'b1;
        va[3] = 16'h8000; vb[3] = 16'h0001; vs[3] = 1'b1;
        for (int k = 4; k < 8; k++) begin
            va[k] = W'($urandom);
            vb[k] = W'($urandom);
            vs[k] = 1'($urandom);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = va[k];
            bus.b     = vb[k];
            bus.sub   = vs[k];
            exp_q.push_back(model(va[k], vb[k], vs[k]));
            n = 0; busy_n = 0; seen = 0;
            while (!seen && n < 20) begin
                @(negedge clk);
                n++;
                if (n == 1) bus.start = 1'b0;
                if (bus.busy === 1'b1) begin
                    busy_n++;
                    // Inputs wander during RUN; the latched operands must win.
                    bus.a   = W'($urandom);
                    bus.b   = W'($urandom);
                    bus.sub = 1'($urandom);
                end
                if (bus.done === 1'b1) seen = 1;
            end
            e = exp_q.pop_front();
            total++;
            if (!seen) begin
                bad++; $display("FAIL arith_timeout[%0d]: no done within %0d cycles", k, n);
            end else begin
                if (bus.s !== e.s) begin
                    bad++; $display("FAIL arith_s[%0d]: got %h want %h", k, bus.s, e.s);
                end
                total++; if (bus.co !== e.co) begin
                    bad++; $display("FAIL arith_co[%0d]: got %b want %b", k, bus.co, e.co);
                end
                total++; if (bus.ov !== e.ov) begin
                    bad++; $display("FAIL arith_ov[%0d]: got %b want %b", k, bus.ov, e.ov);
                end
                total++; if (n !== NSTEP + 1) begin
                    bad++; $display("FAIL arith_latency[%0d]: got %0d want %0d", k, n, NSTEP + 1);
                end
                total++; if (busy_n !== NSTEP) begin
                    bad++; $display("FAIL arith_busy_len[%0d]: got %0d want %0d", k, busy_n, NSTEP);
                end
                @(negedge clk);
                total++; if (bus.done !== 1'b0) begin
                    bad++; $display("FAIL arith_done_pulse[%0d]: got %b want 0", k, bus.done);
                end
                total++; if (bus.s !== e.s) begin
                    bad++; $display("FAIL arith_hold[%0d]: got %h want %h", k, bus.s, e.s);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        res_t e;
        int   n;
        int   d0;
        bit   seen;
        @(negedge clk);
        d0        = done_cnt;
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0FFF;
        bus.sub   = 1'b0;
        exp_q.push_back(model(16'h1234, 16'h0FFF, 1'b0));
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (n == 2) begin
                bus.start = 1'b1;
                bus.a     = 16'hAAAA;
                bus.b     = 16'h5555;
                bus.sub   = 1'b1;
            end
            if (n == 3) bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1;
        end
        e = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++; $display("FAIL ignore_timeout: no done within %0d cycles", n);
        end else if ({bus.s, bus.co, bus.ov} !== {e.s, e.co, e.ov}) begin
            bad++; $display("FAIL ignore_result: got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                            bus.s, bus.co, bus.ov, e.s, e.co, e.ov);
        end
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 !== 1) begin
            bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   n;
        int   n1;
        int   n2;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.sub   = 1'b0;
        exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
        n = 0; n1 = -1; n2 = -1;
        while (n2 < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n1 > 0 && n == n1 + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                e = exp_q.pop_front();
                total++;
                if ({bus.s, bus.co, bus.ov} !== {e.s, e.co, e.ov}) begin
                    bad++; $display("FAIL b2b_result%0d: got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                                    (n1 < 0) ? 1 : 2, bus.s, bus.co, bus.ov, e.s, e.co, e.ov);
                end
                if (n1 < 0) begin
                    n1      = n;
                    bus.a   = 16'h0003;
                    bus.b   = 16'h0009;
                    bus.sub = 1'b1;
                    exp_q.push_back(model(16'h0003, 16'h0009, 1'b1));
                end else begin
                    n2 = n;
                end
            end
        end
        total++;
        if (n2 < 0) begin
            bad++; $display("FAIL b2b_timeout: second done missing (first at %0d)", n1);
            exp_q.delete();
            bus.start = 1'b0;
        end else if (n2 - n1 !== NSTEP + 1) begin
            bad++; $display("FAIL b2b_spacing: got %0d want %0d", n2 - n1, NSTEP + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        res_t e;
        int   n;
        int   d0;
        bit   seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h4321;
        bus.b     = 16'h1111;
        bus.sub   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        total++; if (bus.s !== '0) begin bad++; $display("FAIL midrst_s: got %h want 0000", bus.s); end
        total++; if ({bus.done, bus.co, bus.ov} !== 3'b000) begin
            bad++; $display("FAIL midrst_flags: got done=%b co=%b ov=%b want 0", bus.done, bus.co, bus.ov);
        end
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0F01;
        bus.sub   = 1'b0;
        exp_q.push_back(model(16'h00FF, 16'h0F01, 1'b0));
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1;
        end
        e = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++; $display("FAIL midrst_timeout: no done within %0d cycles", n);
        end else begin
            if ({bus.s, bus.co, bus.ov} !== {e.s, e.co, e.ov}) begin
                bad++; $display("FAIL midrst_result: got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                                bus.s, bus.co, bus.ov, e.s, e.co, e.ov);
            end
            total++; if (n !== NSTEP + 1) begin
                bad++; $display("FAIL midrst_latency: got %0d want %0d", n, NSTEP + 1);
            end
        end
        repeat (3) @(negedge clk);
        total++; if (done_cnt - d0 !== 1) begin
            bad++; $display("FAIL midrst_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
